// File: rtl/serial_load_595.sv
// serial_load_595: serial-to-parallel front end with a latch strobe sequencer.
// Bits are shifted into a WIDTH-bit register. A completed word is copied to
// pdata, held for one setup cycle, and then strobed into a downstream
// 574-style register with a one-cycle latch pulse.
module serial_load_595 #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             oe_req,
    output logic             busy,
    output logic [WIDTH-1:0] pdata,
    output logic             latch,
    output logic             oe_n,
    output logic             done,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        HOLD   = 2'd2,
        STROBE = 2'd3
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_pdata;
    logic             r_busy;
    logic             r_latch;
    logic             r_done;
    logic             r_overrun;
    logic             r_oe_n;
    logic [WIDTH-1:0] w_shift_next;

    // Next shift-register value if the current sin bit is accepted
    always_comb begin
        w_shift_next = r_shift;
        if (MSB_FIRST != 0) begin
            w_shift_next = {r_shift[WIDTH-2:0], sin};
        end else begin
            w_shift_next = {sin, r_shift[WIDTH-1:1]};
        end
    end

    // Sequencer: shift, word transfer, setup hold, strobe, and error tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_shift   <= '0;
            r_pdata   <= '0;
            r_busy    <= 1'b0;
            r_latch   <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_oe_n    <= 1'b1;
        end else begin
            // Output enable tracks the request with a one-cycle delay in every state
            r_oe_n <= ~oe_req;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_latch <= 1'b0;
                    if (start) begin
                        // A bit arriving alongside start is deliberately dropped
                        r_state   <= SHIFT;
                        r_busy    <= 1'b1;
                        r_count   <= '0;
                        r_shift   <= '0;
                        r_overrun <= 1'b0;
                    end else if (sin_valid) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_overrun <= r_overrun;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        // Abort: restart the word, leaving pdata untouched
                        r_count <= '0;
                        r_shift <= '0;
                    end else if (sin_valid) begin
                        r_shift <= w_shift_next;
                        if (r_count == LAST_IDX) begin
                            r_pdata <= w_shift_next;
                            r_count <= '0;
                            r_state <= HOLD;
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end else begin
                        r_count <= r_count;
                    end
                end
                HOLD: begin
                    // pdata has been stable for a full cycle before latch rises
                    r_latch <= 1'b1;
                    r_state <= STROBE;
                end
                STROBE: begin
                    r_latch <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_latch <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign pdata   = r_pdata;
    assign latch   = r_latch;
    assign oe_n    = r_oe_n;
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_serial_load_595.sv
// Directed testbench for serial_load_595: one MSB-first and one LSB-first
// instance share the same stimulus and are checked against hand-computed words.
module tb_serial_load_595;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sin;
    logic       sin_valid;
    logic       oe_req;

    logic       busy_m,    busy_l;
    logic [7:0] pdata_m,   pdata_l;
    logic       latch_m,   latch_l;
    logic       oe_n_m,    oe_n_l;
    logic       done_m,    done_l;
    logic       overrun_m, overrun_l;

    int n_assert = 0;
    int n_fail   = 0;
    int n_latch  = 0;
    int latch_base;

    serial_load_595 #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid),
        .oe_req(oe_req), .busy(busy_m), .pdata(pdata_m), .latch(latch_m),
        .oe_n(oe_n_m), .done(done_m), .overrun(overrun_m)
    );

    serial_load_595 #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid),
        .oe_req(oe_req), .busy(busy_l), .pdata(pdata_l), .latch(latch_l),
        .oe_n(oe_n_l), .done(done_l), .overrun(overrun_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count latch pulses of the MSB-first instance
    always @(posedge clk) begin
        if (latch_m === 1'b1) n_latch <= n_latch + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start a word, shift bits[7]..bits[0], and follow the strobe through done
    task automatic run_word(input logic [7:0] bits, input logic [7:0] exp_m,
                            input logic [7:0] exp_l);
        start = 1'b1; sin_valid = 1'b0; sin = 1'b0;
        tick();
        start = 1'b0;
        chk("busy_after_start", {15'd0, busy_m}, 16'd1);
        chk("done_clear_after_start", {15'd0, done_m}, 16'd0);
        for (int i = 7; i >= 0; i--) begin
            sin_valid = 1'b1; sin = bits[i];
            tick();
            if (i != 0) chk("no_latch_while_shifting", {15'd0, latch_m}, 16'd0);
        end
        sin_valid = 1'b0; sin = 1'b0;
        chk("pdata_msb_first", {8'd0, pdata_m}, {8'd0, exp_m});
        chk("pdata_lsb_first", {8'd0, pdata_l}, {8'd0, exp_l});
        chk("hold_latch_low", {15'd0, latch_m}, 16'd0);
        chk("hold_busy_high", {15'd0, busy_m}, 16'd1);
        tick();
        chk("strobe_latch_high", {15'd0, latch_m}, 16'd1);
        chk("strobe_latch_high_lsb", {15'd0, latch_l}, 16'd1);
        chk("strobe_done_low", {15'd0, done_m}, 16'd0);
        chk("strobe_pdata_stable", {8'd0, pdata_m}, {8'd0, exp_m});
        tick();
        chk("end_latch_low", {15'd0, latch_m}, 16'd0);
        chk("end_done_high", {15'd0, done_m}, 16'd1);
        chk("end_busy_low", {15'd0, busy_m}, 16'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sin = 1'b0; sin_valid = 1'b0; oe_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_pdata", {8'd0, pdata_m}, 16'h0000);
        chk("rst_busy", {15'd0, busy_m}, 16'd0);
        chk("rst_latch", {15'd0, latch_m}, 16'd0);
        chk("rst_done", {15'd0, done_m}, 16'd0);
        chk("rst_overrun", {15'd0, overrun_m}, 16'd0);
        chk("rst_oe_n", {15'd0, oe_n_m}, 16'd1);
        tick(); tick();
        chk("idle_busy", {15'd0, busy_m}, 16'd0);
        chk("idle_latch", {15'd0, latch_m}, 16'd0);
        chk("idle_pdata", {8'd0, pdata_l}, 16'h0000);

        // Stream 1,0,1,0,0,1,0,1: A5 both ways (palindrome)
        run_word(8'hA5, 8'hA5, 8'hA5);
        tick();
        chk("done_one_cycle", {15'd0, done_m}, 16'd0);

        // Stream 1,1,0,0,0,0,0,0: C0 MSB-first, 03 LSB-first
        run_word(8'hC0, 8'hC0, 8'h03);
        tick();

        // Partial word with gaps, then abort by a new start
        latch_base = n_latch;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sin_valid = 1'b1; sin = 1'b1;
            tick();
        end
        sin_valid = 1'b0; sin = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("gap_busy_held", {15'd0, busy_m}, 16'd1);
        chk("gap_pdata_unchanged", {8'd0, pdata_m}, 16'h00C0);
        chk("gap_latch_low", {15'd0, latch_m}, 16'd0);
        run_word(8'h3C, 8'h3C, 8'h3C);
        tick();
        chk("abort_single_latch", n_latch - latch_base, 16'd1);

        // Overrun is sticky in IDLE until the next start
        sin_valid = 1'b1; sin = 1'b1;
        tick();
        sin_valid = 1'b0; sin = 1'b0;
        chk("overrun_set", {15'd0, overrun_m}, 16'd1);
        tick(); tick();
        chk("overrun_sticky", {15'd0, overrun_m}, 16'd1);
        chk("overrun_no_busy", {15'd0, busy_m}, 16'd0);

        // oe_n follows ~oe_req one edge later
        oe_req = 1'b1;
        #1;
        chk("oe_n_before_edge", {15'd0, oe_n_m}, 16'd1);
        tick();
        chk("oe_n_low", {15'd0, oe_n_m}, 16'd0);
        oe_req = 1'b0;
        #1;
        chk("oe_n_still_low", {15'd0, oe_n_m}, 16'd0);
        tick();
        chk("oe_n_high", {15'd0, oe_n_m}, 16'd1);

        // Start clears overrun; start with sin_valid drops that bit
        start = 1'b1; sin_valid = 1'b1; sin = 1'b1;
        tick();
        start = 1'b0;
        chk("overrun_cleared", {15'd0, overrun_m}, 16'd0);
        // Word 0x55 = 0,1,0,1,0,1,0,1 then reset in the HOLD cycle
        for (int i = 0; i < 8; i++) begin
            sin_valid = 1'b1; sin = (i % 2 == 1) ? 1'b1 : 1'b0;
            tick();
        end
        sin_valid = 1'b0; sin = 1'b0;
        chk("pre_rst_pdata_m", {8'd0, pdata_m}, 16'h0055);
        chk("pre_rst_pdata_l", {8'd0, pdata_l}, 16'h00AA);
        latch_base = n_latch;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_latch", {15'd0, latch_m}, 16'd0);
        chk("mid_rst_pdata", {8'd0, pdata_m}, 16'h0000);
        chk("mid_rst_busy", {15'd0, busy_m}, 16'd0);
        tick(); tick();
        chk("mid_rst_no_latch", n_latch - latch_base, 16'd0);
        chk("mid_rst_no_done", {15'd0, done_m}, 16'd0);

        // Normal word after reset, then a back-to-back word started in the done cycle
        run_word(8'h81, 8'h81, 8'h81);
        run_word(8'h0F, 8'h0F, 8'hF0);
        tick();
        chk("final_idle_busy", {15'd0, busy_m}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
